// File: rtl/noc_link_pkg.sv
// Shared definitions for the off-chip NoC link arbiter: source NoC ids, FSM
// state encoding, message-header length field defaults and id helpers.
package noc_link_pkg;

    // Source NoC ids as carried on out_noc_id; 0 means "no source".
    localparam logic [1:0] NOC_ID_NONE = 2'd0;
    localparam logic [1:0] NOC_ID_NOC1 = 2'd1;
    localparam logic [1:0] NOC_ID_NOC2 = 2'd2;
    localparam logic [1:0] NOC_ID_NOC3 = 2'd3;

    // Payload-length field of the message header flit.
    localparam int unsigned LEN_LSB_DEF   = 22;
    localparam int unsigned LEN_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } link_state_e;

    // Round-robin successor: noc1 -> noc2 -> noc3 -> noc1.
    function automatic logic [1:0] next_noc_id(input logic [1:0] id);
        logic [1:0] nxt;
        unique case (id)
            NOC_ID_NOC1: nxt = NOC_ID_NOC2;
            NOC_ID_NOC2: nxt = NOC_ID_NOC3;
            default:     nxt = NOC_ID_NOC1;
        endcase
        return nxt;
    endfunction

    function automatic logic [2:0] id_to_onehot(input logic [1:0] id);
        logic [2:0] oh;
        unique case (id)
            NOC_ID_NOC1: oh = 3'b001;
            NOC_ID_NOC2: oh = 3'b010;
            NOC_ID_NOC3: oh = 3'b100;
            default:     oh = 3'b000;
        endcase
        return oh;
    endfunction

    function automatic logic [1:0] onehot_to_id(input logic [2:0] oh);
        logic [1:0] id;
        unique case (oh)
            3'b001:  id = NOC_ID_NOC1;
            3'b010:  id = NOC_ID_NOC2;
            3'b100:  id = NOC_ID_NOC3;
            default: id = NOC_ID_NONE;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/noc_rr_arb3.sv
// 3-way combinational round-robin picker: returns a one-hot grant for the first
// requester found at or after the pointer (ptr uses the 1..3 NoC id encoding).
module noc_rr_arb3
    import noc_link_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] grant
);

    // Priority chain rotated so that the pointed-to requester is checked first.
    always_comb begin
        grant = 3'b000;
        unique case (ptr)
            NOC_ID_NOC2: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            NOC_ID_NOC3: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/noc_offchip_link_arb.sv
// Packet-level round-robin merge of noc1/noc2/noc3 onto one off-chip flit link.
// A grant is held for a whole packet (length taken from the header flit) so
// packets never interleave; each link flit is tagged with its source NoC id.
// Optional stall watchdog: define NOC_LINK_ARB_WDOG_EN to enable wdog_err.
module noc_offchip_link_arb
    import noc_link_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned LEN_LSB     = LEN_LSB_DEF,
    parameter int unsigned LEN_WIDTH   = LEN_WIDTH_DEF,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [DATA_WIDTH-1:0] noc1_in_data,
    input  logic                  noc1_in_val,
    output logic                  noc1_in_rdy,
    input  logic [DATA_WIDTH-1:0] noc2_in_data,
    input  logic                  noc2_in_val,
    output logic                  noc2_in_rdy,
    input  logic [DATA_WIDTH-1:0] noc3_in_data,
    input  logic                  noc3_in_val,
    output logic                  noc3_in_rdy,

    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [1:0]            out_noc_id,
    output logic                  out_head,
    output logic                  out_tail,
    output logic                  wdog_err
);

    link_state_e           state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;

    logic [2:0]            in_val_vec;
    logic [2:0]            arb_grant;
    logic [2:0]            rdy_vec;
    logic                  sel_val;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [LEN_WIDTH-1:0]  hdr_len;
    logic                  xfer;

    assign in_val_vec = {noc3_in_val, noc2_in_val, noc1_in_val};

    noc_rr_arb3 u_rr_arb (
        .req   (in_val_vec),
        .ptr   (ptr_q),
        .grant (arb_grant)
    );

    // Select the locked source's flit for pass-through.
    always_comb begin
        sel_val  = 1'b0;
        sel_data = '0;
        unique case (grant_q)
            NOC_ID_NOC1: begin sel_val = noc1_in_val; sel_data = noc1_in_data; end
            NOC_ID_NOC2: begin sel_val = noc2_in_val; sel_data = noc2_in_data; end
            NOC_ID_NOC3: begin sel_val = noc3_in_val; sel_data = noc3_in_data; end
            default: ;
        endcase
    end

    assign hdr_len = sel_data[LEN_LSB +: LEN_WIDTH];

    // Next-state and link outputs; flits only move in HEAD/BODY.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        out_val    = 1'b0;
        out_data   = '0;
        out_noc_id = NOC_ID_NONE;
        out_head   = 1'b0;
        out_tail   = 1'b0;
        rdy_vec    = 3'b000;
        xfer       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|in_val_vec) begin
                    grant_d = onehot_to_id(arb_grant);
                    state_d = HEAD;
                end
            end
            HEAD: begin
                out_val    = sel_val;
                out_data   = sel_data;
                out_noc_id = grant_q;
                out_head   = 1'b1;
                out_tail   = (hdr_len == '0);
                rdy_vec    = id_to_onehot(grant_q) & {3{out_rdy}};
                xfer       = sel_val & out_rdy;
                if (xfer) begin
                    rem_d = hdr_len;
                    if (hdr_len == '0) begin
                        ptr_d   = next_noc_id(grant_q);
                        state_d = IDLE;
                    end else begin
                        state_d = BODY;
                    end
                end
            end
            BODY: begin
                out_val    = sel_val;
                out_data   = sel_data;
                out_noc_id = grant_q;
                out_tail   = (rem_q == LEN_WIDTH'(1));
                rdy_vec    = id_to_onehot(grant_q) & {3{out_rdy}};
                xfer       = sel_val & out_rdy;
                if (xfer) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_WIDTH'(1)) begin
                        ptr_d   = next_noc_id(grant_q);
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign noc1_in_rdy = rdy_vec[0];
    assign noc2_in_rdy = rdy_vec[1];
    assign noc3_in_rdy = rdy_vec[2];

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= NOC_ID_NONE;
            ptr_q   <= NOC_ID_NOC1;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

`ifdef NOC_LINK_ARB_WDOG_EN
    localparam int unsigned       WdogW   = $clog2(WDOG_CYCLES + 1);
    localparam logic [WdogW-1:0]  WdogMax = WdogW'(WDOG_CYCLES);

    logic [WdogW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic             wdog_err_q, wdog_err_d;

    // Count consecutive locked cycles without a transfer; saturates at the limit.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        wdog_err_d = wdog_err_q;
        if (state_q == IDLE || xfer) begin
            wdog_cnt_d = '0;
        end else if (wdog_cnt_q != WdogMax) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
        if (wdog_cnt_d == WdogMax) begin
            wdog_err_d = 1'b1;
        end
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    logic unused_wdog_cycles;
    assign unused_wdog_cycles = ^WDOG_CYCLES;
    assign wdog_err           = 1'b0;
`endif

endmodule
